pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 HZ_NOP  input  1  load-use stall request from the data hazard detection unit, same-cycle combinational.
REQ-004 BR_TAKEN  input  1  control transfer resolved taken in ID, same-cycle.
REQ-005 MC_START  input  1  multi-cycle operation entering EX this cycle.
REQ-006 MC_LAT  input  4  extra EX cycles the multi-cycle op needs; 0..15, sampled only with MC_START=1.
REQ-007 CNT_CLR  input  1  synchronous clear of the stall performance counter.
REQ-008 PC_LE  output  1  PC load enable.
REQ-009 IF_ID_LE  output  1  IF/ID pipeline register load enable.
REQ-010 IF_ID_CLR  output  1  flush IF/ID to NOP at next edge.
REQ-011 ID_EX_NOP  output  1  force bubble into ID/EX at next edge.
REQ-012 EX_HOLD  output  1  freeze ID/EX and EX/MEM registers.
REQ-013 STATE  output  2  current FSM state: RUN=2'b00, MC_WAIT=2'b01.
REQ-014 STALL_CNT  output  8  saturating count of cycles with PC_LE=0.

Function
REQ-015 FSM has two legal states, RUN and MC_WAIT; encodings 2'b10/2'b11 SHALL transition to RUN next cycle with RUN outputs.
REQ-016 Outputs SHALL be combinational from current state and current-cycle inputs (Mealy), zero-cycle latency to the hazard inputs.
REQ-017 RUN, no requests: PC_LE=1, IF_ID_LE=1, IF_ID_CLR=0, ID_EX_NOP=0, EX_HOLD=0.
REQ-018 RUN priority, highest first: MC_START with MC_LAT!=0, then HZ_NOP, then BR_TAKEN.
REQ-019 RUN with MC_START=1, MC_LAT=N>0: PC_LE=0, IF_ID_LE=0, EX_HOLD=1, ID_EX_NOP=0, IF_ID_CLR=0; load down-counter with N; next state MC_WAIT.
REQ-020 MC_START=1 with MC_LAT=0 SHALL be ignored (no stall, no state change); lower-priority requests are then evaluated normally.
REQ-021 RUN with HZ_NOP=1 (no MC stall): PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1, IF_ID_CLR=0; BR_TAKEN in the same cycle SHALL be suppressed (branch re-resolves after the bubble).
REQ-022 RUN with BR_TAKEN=1 only: PC_LE=1, IF_ID_LE=1, IF_ID_CLR=1, ID_EX_NOP=0.
REQ-023 MC_WAIT: PC_LE=0, IF_ID_LE=0, EX_HOLD=1, ID_EX_NOP=0, IF_ID_CLR=0; HZ_NOP, BR_TAKEN, MC_START ignored; counter decrements each cycle.
REQ-024 MC_WAIT: when counter equals 1, next state SHALL be RUN and counter 0; total stall = N+1 cycles with EX_HOLD=1 (the RUN entry cycle plus N).
REQ-025 STALL_CNT increments by 1 on every edge where PC_LE=0, saturates at 8'hFF, never wraps.
REQ-026 CNT_CLR=1 SHALL force STALL_CNT to 0 at next edge, overriding an increment in the same cycle.

Reset
REQ-027 reset=1 SHALL put FSM in RUN, MC counter to 0, STALL_CNT to 0 at next edge, including mid-MC_WAIT.
REQ-028 During a reset cycle outputs SHALL follow RUN decoding of the current inputs; after reset the first cycle is RUN.

Structure
REQ-029 Shared package pipe_ctrl_pkg SHALL hold the state encoding (RUN, MC_WAIT), MC_LAT width (4) and STALL_CNT width (8).
REQ-030 The saturating performance counter SHALL be a sub-module named sat_counter (parameterised width, inc, clr, sync reset).
REQ-031 FSM, MC down-counter and output decode SHALL reside in pipeline_ctrl.

Verification
REQ-032 After reset, idle inputs -> PC_LE=1, IF_ID_LE=1, other outputs 0, STATE=00, STALL_CNT=0.
REQ-033 HZ_NOP=1 and BR_TAKEN=1 for one cycle in RUN -> ID_EX_NOP=1, PC_LE=0, IF_ID_CLR=0; STALL_CNT=1 next cycle.
REQ-034 MC_START=1, MC_LAT=3 -> EX_HOLD=1 for exactly 4 cycles, STATE=01 for 3 cycles, RUN on 5th; HZ_NOP asserted mid-wait causes no ID_EX_NOP.
REQ-035 MC_START=1, MC_LAT=0 with BR_TAKEN=1 -> no stall, IF_ID_CLR=1, STATE stays 00.
REQ-036 reset asserted in 2nd MC_WAIT cycle of MC_LAT=15 -> STATE=00, STALL_CNT=0 next cycle, EX_HOLD=0 with idle inputs.
REQ-037 HZ_NOP held 300 cycles -> STALL_CNT saturates at 255; CNT_CLR=1 with HZ_NOP=1 -> STALL_CNT=0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Holds the FSM state encoding and the widths of the multi-cycle latency
// field and the stall performance counter.
package pipe_ctrl_pkg;

  localparam int STATE_W     = 2;
  localparam int MC_LAT_W    = 4;
  localparam int STALL_CNT_W = 8;

  // Only RUN and MC_WAIT are legal; 2'b10 / 2'b11 decode as RUN and recover.
  localparam logic [STATE_W-1:0] ST_RUN     = 2'b00;
  localparam logic [STATE_W-1:0] ST_MC_WAIT = 2'b01;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: saturating up-counter.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset to 0
//   clr_i - synchronous clear to 0, wins over inc_i
//   inc_i - add 1 at the next edge unless already at all-ones
//   cnt_o - current count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall / flush controller for a 5-stage pipeline.
// Decodes load-use hazards, taken branches and multi-cycle EX operations
// into register load enables, flush and bubble controls, and counts the
// cycles the PC is held.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   HZ_NOP               - load-use stall request (same cycle)
//   BR_TAKEN             - branch resolved taken in ID (same cycle)
//   MC_START, MC_LAT     - multi-cycle op enters EX, needing MC_LAT extra cycles
//   CNT_CLR              - clear the stall counter
//   PC_LE, IF_ID_LE      - PC / IF-ID load enables
//   IF_ID_CLR, ID_EX_NOP - flush IF/ID, inject bubble into ID/EX
//   EX_HOLD              - freeze ID/EX and EX/MEM
//   STATE                - current FSM state (RUN=00, MC_WAIT=01)
//   STALL_CNT            - saturating count of cycles with PC_LE=0
// All request inputs are level-sensitive and act in the cycle they are high;
// there is no valid/ready handshake, every output is a same-cycle decode.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   HZ_NOP,
  input  logic                   BR_TAKEN,
  input  logic                   MC_START,
  input  logic [MC_LAT_W-1:0]    MC_LAT,
  input  logic                   CNT_CLR,
  output logic                   PC_LE,
  output logic                   IF_ID_LE,
  output logic                   IF_ID_CLR,
  output logic                   ID_EX_NOP,
  output logic                   EX_HOLD,
  output logic [STATE_W-1:0]     STATE,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [MC_LAT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                in_wait;

  // While reset is high the outputs decode as RUN, even mid-MC_WAIT.
  assign in_wait = (state_q == ST_MC_WAIT) && !reset;

  always_comb begin
    state_d   = ST_RUN;
    mc_cnt_d  = '0;
    PC_LE     = 1'b1;
    IF_ID_LE  = 1'b1;
    IF_ID_CLR = 1'b0;
    ID_EX_NOP = 1'b0;
    EX_HOLD   = 1'b0;
    if (in_wait) begin
      // Requests are ignored while the multi-cycle op occupies EX.
      PC_LE    = 1'b0;
      IF_ID_LE = 1'b0;
      EX_HOLD  = 1'b1;
      // Counter value 1 is the last wait cycle; <=1 also recovers from 0.
      if (mc_cnt_q > 4'd1) begin
        state_d  = ST_MC_WAIT;
        mc_cnt_d = mc_cnt_q - 1'b1;
      end
    end else if (MC_START && (MC_LAT != '0)) begin
      PC_LE    = 1'b0;
      IF_ID_LE = 1'b0;
      EX_HOLD  = 1'b1;
      state_d  = ST_MC_WAIT;
      mc_cnt_d = MC_LAT;
    end else if (HZ_NOP) begin
      // A same-cycle branch is dropped; it re-resolves after the bubble.
      PC_LE     = 1'b0;
      IF_ID_LE  = 1'b0;
      ID_EX_NOP = 1'b1;
    end else if (BR_TAKEN) begin
      IF_ID_CLR = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  assign STATE = state_q;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (CNT_CLR),
    .inc_i (!PC_LE),
    .cnt_o (STALL_CNT)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model via an expected queue.
module tb_pipeline_ctrl;

  localparam int W = 15; // {PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_HOLD, STATE[1:0], STALL_CNT[7:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       HZ_NOP = 1'b0;
  logic       BR_TAKEN = 1'b0;
  logic       MC_START = 1'b0;
  logic [3:0] MC_LAT = 4'd0;
  logic       CNT_CLR = 1'b0;
  logic       PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_HOLD;
  logic [1:0] STATE;
  logic [7:0] STALL_CNT;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];

  // Model state: remaining MC wait cycles (0 = RUN) and stall count.
  int m_wait = 0;
  int m_stall = 0;

  pipeline_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .HZ_NOP    (HZ_NOP),
    .BR_TAKEN  (BR_TAKEN),
    .MC_START  (MC_START),
    .MC_LAT    (MC_LAT),
    .CNT_CLR   (CNT_CLR),
    .PC_LE     (PC_LE),
    .IF_ID_LE  (IF_ID_LE),
    .IF_ID_CLR (IF_ID_CLR),
    .ID_EX_NOP (ID_EX_NOP),
    .EX_HOLD   (EX_HOLD),
    .STATE     (STATE),
    .STALL_CNT (STALL_CNT)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge and, when chk is set,
  // pushes the model's expected outputs for that cycle, then advances the model.
  task automatic drive(input logic rst, input logic hz, input logic br,
                       input logic mcs, input logic [3:0] lat, input logic clr,
                       input logic chk, input string nm);
    logic pc, ifid, ifclr, nop, hold;
    logic [1:0] st;
    @(negedge clk);
    reset = rst; HZ_NOP = hz; BR_TAKEN = br; MC_START = mcs; MC_LAT = lat; CNT_CLR = clr;
    st = (m_wait > 0) ? 2'b01 : 2'b00;
    pc = 1'b1; ifid = 1'b1; ifclr = 1'b0; nop = 1'b0; hold = 1'b0;
    if ((!rst && m_wait > 0) || (mcs && lat != 0)) begin
      pc = 1'b0; ifid = 1'b0; hold = 1'b1;
    end else if (hz) begin
      pc = 1'b0; ifid = 1'b0; nop = 1'b1;
    end else if (br) begin
      ifclr = 1'b1;
    end
    if (chk) begin
      exp_q.push_back({pc, ifid, ifclr, nop, hold, st, m_stall[7:0]});
      name_q.push_back(nm);
    end
    if (rst) begin
      m_wait = 0;
      m_stall = 0;
    end else begin
      if (m_wait > 0) m_wait = m_wait - 1;
      else if (mcs && lat != 0) m_wait = int'(lat);
      if (clr) m_stall = 0;
      else if (!pc && m_stall < 255) m_stall = m_stall + 1;
    end
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    string nm;
    #2;
    cycle++;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {PC_LE, IF_ID_LE, IF_ID_CLR, ID_EX_NOP, EX_HOLD, STATE, STALL_CNT};
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL %s cycle %0d: got pc=%b ifid=%b clr=%b nop=%b hold=%b st=%b cnt=%0d, want pc=%b ifid=%b clr=%b nop=%b hold=%b st=%b cnt=%0d",
                 nm, cycle, act[14], act[13], act[12], act[11], act[10], act[9:8], act[7:0],
                 exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    // First reset cycle unchecked: registers are still unknown.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset_init");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "reset_decode");
    idle(3, "post_reset_idle");

    // Hazard plus branch: bubble wins, counter steps to 1.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "hz_and_br");
    idle(2, "after_hz");

    // MC_LAT=3 with HZ_NOP and BR_TAKEN asserted mid-wait.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, "mc3_start");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "mc3_wait_hz");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1, "mc3_wait_br_mc");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "mc3_wait_last");
    idle(2, "mc3_done");

    // MC_LAT=0 is ignored; the branch flush still happens.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, "mc0_br");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, "mc0_hz");
    idle(1, "mc0_done");

    // Reset in the second wait cycle of MC_LAT=15.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, "mc15_start");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "mc15_wait1");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "mc15_reset");
    idle(2, "mc15_after_reset");

    // Saturation, then clear overriding an increment.
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "hz_saturate");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "clr_with_hz");
    idle(2, "after_clr");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_hz, r_br, r_mcs, r_clr;
      logic [3:0] r_lat;
      r_rst = ($urandom_range(0, 99) < 2);
      r_hz  = ($urandom_range(0, 99) < 30);
      r_br  = ($urandom_range(0, 99) < 30);
      r_mcs = ($urandom_range(0, 99) < 15);
      r_lat = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      r_clr = ($urandom_range(0, 99) < 3);
      drive(r_rst, r_hz, r_br, r_mcs, r_lat, r_clr, 1'b1, "random");
    end
    idle(20, "drain");

    @(negedge clk);
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
